and_gate_pbit_array: RTL and testbench

Parametrised successor to the single AND-gate p-bit experiment. Holds NUM_GATES independent three-p-bit AND-gate circuits (A, B, C) in one clock domain. A phase-sequencing FSM replaces the three phase-shifted PLL clocks. Each gate runs in one of four modes (free, clamp-output, clamp-inputs, hold) and has its own 46-bit LFSR. An optional on-chip histogram counts the {A,B,C} states of one selected gate for statistics readout.

---
 rtl/and_gate_pbit_array.sv | 247 ++++++++++++++++++++++++
 tb/tb_and_gate_pbit_array.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/and_gate_pbit_array.sv
// and_gate_pbit_array: NUM_GATES independent three-p-bit AND-gate circuits (A, B, C) sharing one
// clock. A phase FSM (IDLE -> PH_A -> PH_B -> PH_C ... -> DONE) sequences the p-bit updates.
// Each gate has its own 46-bit LFSR and one of four modes: free, clamp C, clamp A/B, hold.
//
// Optional feature macro: AND_PBIT_HIST_EN. When defined, an 8-bin histogram of {A,B,C} for
// one selected gate is built. When undefined, hist_count is tied to 0.
//
// Ports:
//   sample_clk  - sole clock, rising edge
//   rst         - asynchronous active-high reset
//   start       - one-cycle run request, sampled only in IDLE
//   mode        - per-gate mode, 2 bits per gate (00 free, 01 clamp C, 10 clamp A/B, 11 hold)
//   c_clamp     - per-gate C value for mode 01
//   ab_clamp    - per-gate {A,B} values for mode 10, gate i at [2i+1:2i]
//   num_sweeps  - sweeps per run
//   busy        - high during PH_A/PH_B/PH_C
//   done        - one-cycle pulse at end of run
//   m_a/m_b/m_c - p-bit states
//   hist_sel    - gate to histogram (>= NUM_GATES disables counting)
//   hist_addr   - bin index {a,b,c}
//   hist_count  - combinational read of the selected bin
module and_gate_pbit_array #(
  parameter int unsigned NUM_GATES = 4,
  parameter int unsigned SWEEP_W   = 16,
  parameter int unsigned CNT_W     = 16,
  parameter logic [45:0] SEED_BASE = 46'h0B79406AB345
) (
  input  logic                   sample_clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [2*NUM_GATES-1:0] mode,
  input  logic [NUM_GATES-1:0]   c_clamp,
  input  logic [2*NUM_GATES-1:0] ab_clamp,
  input  logic [SWEEP_W-1:0]     num_sweeps,
  output logic                   busy,
  output logic                   done,
  output logic [NUM_GATES-1:0]   m_a,
  output logic [NUM_GATES-1:0]   m_b,
  output logic [NUM_GATES-1:0]   m_c,
  input  logic [5:0]             hist_sel,
  input  logic [2:0]             hist_addr,
  output logic [CNT_W-1:0]       hist_count
);

  typedef enum logic [2:0] {StIdle, StPhA, StPhB, StPhC, StDone} state_e;

  // Seed for gate idx: SEED_BASE rotated left by 7*idx.
  function automatic logic [45:0] rotl_seed(int unsigned idx);
    logic [91:0] dbl;
    int unsigned r;
    dbl = {SEED_BASE, SEED_BASE};
    r   = (7 * idx) % 46;
    return dbl[91 - r -: 46];
  endfunction

  state_e state_q, state_d;
  logic   run_start;
  logic   last_sweep;

  logic [SWEEP_W-1:0]     sweep_cnt_q, sweep_cnt_d;
  logic [SWEEP_W:0]       sweep_nxt;
  logic [2*NUM_GATES-1:0] mode_q, mode_d;
  logic [NUM_GATES-1:0]   c_clamp_q, c_clamp_d;
  logic [2*NUM_GATES-1:0] ab_clamp_q, ab_clamp_d;
  logic [SWEEP_W-1:0]     num_sweeps_q, num_sweeps_d;
  logic [NUM_GATES-1:0]   c_next;

  assign run_start  = (state_q == StIdle) && start;
  assign sweep_nxt  = {1'b0, sweep_cnt_q} + {{SWEEP_W{1'b0}}, 1'b1};
  assign last_sweep = sweep_nxt >= {1'b0, num_sweeps_q};

  // State register
  always_ff @(posedge sample_clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; the zero-sweep check uses the live input since it is latched on this edge.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = (num_sweeps == '0) ? StDone : StPhA;
      StPhA:   state_d = StPhB;
      StPhB:   state_d = StPhC;
      StPhC:   state_d = last_sweep ? StDone : StPhA;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs
  always_comb begin
    busy = (state_q == StPhA) || (state_q == StPhB) || (state_q == StPhC);
    done = (state_q == StDone);
  end

  // Run configuration and sweep counter
  always_comb begin
    mode_d       = mode_q;
    c_clamp_d    = c_clamp_q;
    ab_clamp_d   = ab_clamp_q;
    num_sweeps_d = num_sweeps_q;
    sweep_cnt_d  = sweep_cnt_q;
    if (run_start) begin
      mode_d       = mode;
      c_clamp_d    = c_clamp;
      ab_clamp_d   = ab_clamp;
      num_sweeps_d = num_sweeps;
      sweep_cnt_d  = '0;
    end else if (state_q == StPhC && !last_sweep) begin
      sweep_cnt_d = sweep_nxt[SWEEP_W-1:0];
    end
  end

  always_ff @(posedge sample_clk or posedge rst) begin
    if (rst) begin
      mode_q       <= '0;
      c_clamp_q    <= '0;
      ab_clamp_q   <= '0;
      num_sweeps_q <= '0;
      sweep_cnt_q  <= '0;
    end else begin
      mode_q       <= mode_d;
      c_clamp_q    <= c_clamp_d;
      ab_clamp_q   <= ab_clamp_d;
      num_sweeps_q <= num_sweeps_d;
      sweep_cnt_q  <= sweep_cnt_d;
    end
  end

  for (genvar g = 0; g < NUM_GATES; g++) begin : g_gate
    localparam logic [45:0] Seed = rotl_seed(g);

    logic [45:0] lfsr_q, lfsr_d;
    logic        a_q, a_d, b_q, b_d, c_q, c_d;
    logic [1:0]  gmode;
    logic        rng_a, rng_b;

    // LFSR free-runs every cycle, independent of FSM state.
    assign lfsr_d = {lfsr_q[44:0], lfsr_q[45] ^ lfsr_q[39] ^ lfsr_q[38] ^ lfsr_q[37]};
    assign rng_a  = lfsr_q[13];
    assign rng_b  = lfsr_q[29];
    assign gmode  = mode_q[2*g+1 -: 2];

    // Each phase touches only its own p-bit, reading registered values of the others.
    always_comb begin
      a_d = a_q;
      b_d = b_q;
      c_d = c_q;
      unique case (state_q)
        StPhA: begin
          case (gmode)
            2'b00:   a_d = rng_a;
            2'b01:   a_d = c_clamp_q[g] | (~b_q & rng_a);
            2'b10:   a_d = ab_clamp_q[2*g+1];
            default: ;
          endcase
        end
        StPhB: begin
          case (gmode)
            2'b00:   b_d = rng_b;
            2'b01:   b_d = c_clamp_q[g] | (~a_q & rng_b);
            2'b10:   b_d = ab_clamp_q[2*g];
            default: ;
          endcase
        end
        StPhC: begin
          case (gmode)
            2'b00, 2'b10: c_d = a_q & b_q;
            2'b01:        c_d = c_clamp_q[g];
            default:      ;
          endcase
        end
        default: ;
      endcase
    end

    always_ff @(posedge sample_clk or posedge rst) begin
      if (rst) begin
        lfsr_q <= Seed;
        a_q    <= 1'b0;
        b_q    <= 1'b0;
        c_q    <= 1'b0;
      end else begin
        lfsr_q <= lfsr_d;
        a_q    <= a_d;
        b_q    <= b_d;
        c_q    <= c_d;
      end
    end

    assign m_a[g]    = a_q;
    assign m_b[g]    = b_q;
    assign m_c[g]    = c_q;
    assign c_next[g] = c_d;
  end

`ifdef AND_PBIT_HIST_EN
  logic [5:0]       hist_sel_q, hist_sel_d;
  logic [CNT_W-1:0] hist_q [8];
  logic [CNT_W-1:0] hist_d [8];
  logic             hist_hit;
  logic [2:0]       hist_idx;

  // Bin uses the freshly written C so the count reflects the state after the sweep.
  always_comb begin
    hist_hit = 1'b0;
    hist_idx = '0;
    for (int g = 0; g < NUM_GATES; g++) begin
      if (hist_sel_q == 6'(g)) begin
        hist_hit = 1'b1;
        hist_idx = {m_a[g], m_b[g], c_next[g]};
      end
    end
  end

  always_comb begin
    hist_sel_d = run_start ? hist_sel : hist_sel_q;
    hist_d     = hist_q;
    if (run_start) begin
      for (int b = 0; b < 8; b++) hist_d[b] = '0;
    end else if (state_q == StPhC && hist_hit && hist_q[hist_idx] != '1) begin
      hist_d[hist_idx] = hist_q[hist_idx] + CNT_W'(1);
    end
  end

  always_ff @(posedge sample_clk or posedge rst) begin
    if (rst) begin
      hist_sel_q <= '0;
      for (int b = 0; b < 8; b++) hist_q[b] <= '0;
    end else begin
      hist_sel_q <= hist_sel_d;
      hist_q     <= hist_d;
    end
  end

  assign hist_count = hist_q[hist_addr];
`else
  logic unused_hist;
  assign unused_hist = ^{hist_sel, hist_addr, c_next};
  assign hist_count  = '0;
`endif

endmodule

// File: tb/tb_and_gate_pbit_array.sv
// Directed bench for and_gate_pbit_array with two gates and 4-bit bin counters.
module tb_and_gate_pbit_array;

  localparam int unsigned NG = 2;
  localparam int unsigned SW = 16;
  localparam int unsigned CW = 4;
  localparam logic [45:0] SEED = 46'h0B79406AB345;

  logic            sample_clk = 1'b0;
  logic            rst;
  logic            start;
  logic [2*NG-1:0] mode;
  logic [NG-1:0]   c_clamp;
  logic [2*NG-1:0] ab_clamp;
  logic [SW-1:0]   num_sweeps;
  logic            busy;
  logic            done;
  logic [NG-1:0]   m_a, m_b, m_c;
  logic [5:0]      hist_sel;
  logic [2:0]      hist_addr;
  logic [CW-1:0]   hist_count;

  int checks   = 0;
  int failures = 0;
  int exp_bin [8];

  logic [45:0] lfsr_m;

  and_gate_pbit_array #(
    .NUM_GATES(NG),
    .SWEEP_W  (SW),
    .CNT_W    (CW),
    .SEED_BASE(SEED)
  ) dut (
    .sample_clk(sample_clk),
    .rst       (rst),
    .start     (start),
    .mode      (mode),
    .c_clamp   (c_clamp),
    .ab_clamp  (ab_clamp),
    .num_sweeps(num_sweeps),
    .busy      (busy),
    .done      (done),
    .m_a       (m_a),
    .m_b       (m_b),
    .m_c       (m_c),
    .hist_sel  (hist_sel),
    .hist_addr (hist_addr),
    .hist_count(hist_count)
  );

  always #5 sample_clk = ~sample_clk;

  // Golden LFSR for gate 0
  always_ff @(posedge sample_clk or posedge rst) begin
    if (rst) lfsr_m <= SEED;
    else     lfsr_m <= {lfsr_m[44:0], lfsr_m[45] ^ lfsr_m[39] ^ lfsr_m[38] ^ lfsr_m[37]};
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic clear_exp();
    for (int b = 0; b < 8; b++) exp_bin[b] = 0;
  endtask

  task automatic check_bins(input string tag);
    for (int b = 0; b < 8; b++) begin
      hist_addr = 3'(b);
      #1;
`ifdef AND_PBIT_HIST_EN
      check_eq($sformatf("%s_bin%0d", tag, b), 32'(hist_count), 32'(exp_bin[b]));
`else
      check_eq($sformatf("%s_bin%0d", tag, b), 32'(hist_count), 32'd0);
`endif
    end
  endtask

  task automatic start_run(input logic [3:0] md, input logic [1:0] cc, input logic [3:0] ab,
                           input int n, input logic [5:0] hs);
    @(negedge sample_clk);
    mode       = md;
    c_clamp    = cc;
    ab_clamp   = ab;
    num_sweeps = 16'(n);
    hist_sel   = hs;
    start      = 1'b1;
  endtask

  // Steps cycles 1..3n+1 checking busy/done; optionally re-pulses start at cycle 'poke'.
  task automatic finish_run(input int n, input int poke, input string tag);
    for (int c = 1; c <= 3 * n + 1; c++) begin
      @(negedge sample_clk);
      start = (c == poke);
      if (c == poke) num_sweeps = 16'd9;
      if (c == 1) mode = ~mode;
      if (c == 3 * n + 1) check_eq({tag, "_done"}, 32'({busy, done}), 32'd1);
      else                check_eq({tag, "_busy"}, 32'({busy, done}), 32'd2);
    end
    start = 1'b0;
    @(negedge sample_clk);
    check_eq({tag, "_idle"}, 32'({busy, done}), 32'd0);
  endtask

  // Gate 0 free, gate 1 hold; every p-bit update compared against the LFSR model.
  task automatic free_run(input int n, input string tag);
    logic ea, eb;
    ea = 1'b0;
    eb = 1'b0;
    clear_exp();
    start_run(4'b1100, 2'b00, 4'b0000, n, 6'd0);
    for (int k = 0; k < n; k++) begin
      @(negedge sample_clk);
      start = 1'b0;
      check_eq({tag, "_busy"}, 32'({busy, done}), 32'd2);
      if (k > 0) check_eq({tag, "_c"}, 32'(m_c[0]), 32'(ea & eb));
      ea = lfsr_m[13];
      @(negedge sample_clk);
      check_eq({tag, "_a"}, 32'(m_a[0]), 32'(ea));
      eb = lfsr_m[29];
      @(negedge sample_clk);
      check_eq({tag, "_b"}, 32'(m_b[0]), 32'(eb));
      exp_bin[{ea, eb, ea & eb}]++;
    end
    @(negedge sample_clk);
    check_eq({tag, "_c_last"}, 32'(m_c[0]), 32'(ea & eb));
    check_eq({tag, "_done"}, 32'({busy, done}), 32'd1);
    check_eq({tag, "_g1"}, 32'({m_a[1], m_b[1], m_c[1]}), 32'd0);
    @(negedge sample_clk);
    check_eq({tag, "_idle"}, 32'({busy, done}), 32'd0);
    check_bins(tag);
  endtask

  initial begin
    int sum;
    rst        = 1'b1;
    start      = 1'b0;
    mode       = '0;
    c_clamp    = '0;
    ab_clamp   = '0;
    num_sweeps = '0;
    hist_sel   = '0;
    hist_addr  = '0;

    // Reset state
    repeat (3) @(negedge sample_clk);
    check_eq("rst_pbits", 32'({m_a, m_b, m_c}), 32'd0);
    check_eq("rst_ctl", 32'({busy, done}), 32'd0);
    clear_exp();
    check_bins("rst");
    rst = 1'b0;

    free_run(6, "free");

    // Clamp C=1: all ones, 20 sweeps saturate the 4-bit bin at 15
    start_run(4'b1101, 2'b01, 4'b0000, 20, 6'd0);
    finish_run(20, 0, "c1");
    check_eq("c1_g0", 32'({m_a[0], m_b[0], m_c[0]}), 32'd7);
    check_eq("c1_g1", 32'({m_a[1], m_b[1], m_c[1]}), 32'd0);
    clear_exp();
    exp_bin[7] = 15;
    check_bins("c1");

    // Clamp C=0: A and B never both 1, C stays 0
    start_run(4'b1101, 2'b00, 4'b0000, 12, 6'd0);
    finish_run(12, 0, "c0");
    check_eq("c0_c", 32'(m_c[0]), 32'd0);
    check_eq("c0_ab", 32'(m_a[0] & m_b[0]), 32'd0);
`ifdef AND_PBIT_HIST_EN
    sum = 0;
    for (int b = 0; b < 8; b++) begin
      hist_addr = 3'(b);
      #1;
      if (b == 0 || b == 2 || b == 4) sum += int'(hist_count);
      else check_eq($sformatf("c0_bin%0d", b), 32'(hist_count), 32'd0);
    end
    check_eq("c0_sum", 32'(sum), 32'd12);
`else
    clear_exp();
    check_bins("c0");
`endif

    // Clamp A/B = 01 on gate 0, gate 1 held; three histogram selections
    start_run(4'b1110, 2'b00, 4'b0001, 10, 6'd0);
    finish_run(10, 0, "ab");
    check_eq("ab_g0", 32'({m_a[0], m_b[0], m_c[0]}), 32'd2);
    check_eq("ab_g1", 32'({m_a[1], m_b[1], m_c[1]}), 32'd0);
    clear_exp();
    exp_bin[2] = 10;
    check_bins("ab_sel0");

    start_run(4'b1110, 2'b00, 4'b0001, 10, 6'd1);
    finish_run(10, 0, "ab1");
    clear_exp();
    exp_bin[0] = 10;
    check_bins("ab_sel1");

    start_run(4'b1110, 2'b00, 4'b0001, 10, 6'd7);
    finish_run(10, 0, "ab7");
    clear_exp();
    check_bins("ab_sel7");

    // Zero sweeps: done in cycle 1, p-bits untouched, bins cleared
    start_run(4'b1111, 2'b00, 4'b0001, 5, 6'd0);
    finish_run(5, 0, "pre0");
    start_run(4'b0000, 2'b11, 4'b1111, 0, 6'd0);
    finish_run(0, 0, "zero");
    check_eq("zero_g0", 32'({m_a[0], m_b[0], m_c[0]}), 32'd2);
    clear_exp();
    check_bins("zero");

    // Start while busy is ignored: run stays 3 sweeps
    start_run(4'b1111, 2'b00, 4'b0000, 3, 6'd0);
    finish_run(3, 4, "poke");
    clear_exp();
    exp_bin[2] = 3;
    check_bins("poke");

    // Abort mid-run at cycle 16, then rerun from reset
    start_run(4'b1100, 2'b00, 4'b0000, 100, 6'd0);
    for (int c = 1; c <= 15; c++) begin
      @(negedge sample_clk);
      start = 1'b0;
      check_eq("abort_busy", 32'({busy, done}), 32'd2);
    end
    @(negedge sample_clk);
    rst = 1'b1;
    #1;
    check_eq("abort_ctl", 32'({busy, done}), 32'd0);
    check_eq("abort_pbits", 32'({m_a, m_b, m_c}), 32'd0);
    clear_exp();
    check_bins("abort");
    repeat (3) begin
      @(negedge sample_clk);
      check_eq("abort_nodone", 32'(done), 32'd0);
    end
    rst = 1'b0;
    free_run(5, "rerun");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
